// File: rtl/diff_input_filter.sv
// Differential-pair input conditioner: resolves each P/N pair, synchronizes it, debounces it,
// and reports edges plus sticky invalid-state (I==IB) flags and a shared saturating error count.
module diff_input_filter #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_LEN  = 4,
  parameter logic [CHANNELS-1:0] INVERT      = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] I,
  input  logic [CHANNELS-1:0] IB,
  output logic [CHANNELS-1:0] O,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL,
  output logic [CHANNELS-1:0] INVALID,
  input  logic                INVALID_CLR,
  output logic [7:0]          ERR_CNT
);

  localparam int              CW       = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CHANNELS-1:0] w_raw;
  logic [CHANNELS-1:0] w_inv_raw;
  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_sinv;
  logic [CHANNELS-1:0] w_sinv_rise;
  logic [8:0]          w_err_sum;

  logic [CHANNELS-1:0] r_sync     [SYNC_STAGES];
  logic [CHANNELS-1:0] r_sync_inv [SYNC_STAGES];
  logic [CW-1:0]       r_cnt      [CHANNELS];
  logic [CHANNELS-1:0] r_o;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_invalid;
  logic [CHANNELS-1:0] r_sinv_prev;
  logic [7:0]          r_err_cnt;

  // An illegal pair (I==IB) resolves to 0 before the polarity swap.
  assign w_raw     = (I & ~IB) ^ INVERT;
  assign w_inv_raw = ~(I ^ IB);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the synchronizer array is small flop storage, not RAM, so it is reset like any register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k]     <= '0;
        r_sync_inv[k] <= '0;
      end
    end else begin
      r_sync[0]     <= w_raw;
      r_sync_inv[0] <= w_inv_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k]     <= r_sync[k-1];
        r_sync_inv[k] <= r_sync_inv[k-1];
      end
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_sinv = r_sync_inv[SYNC_STAGES-1];

  // Debounce: the output only follows after FILTER_LEN consecutive cycles of disagreement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int ch = 0; ch < CHANNELS; ch++) r_cnt[ch] <= '0;
      r_o    <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (w_s[ch] == r_o[ch]) begin
          r_cnt[ch] <= '0;
        end else if (r_cnt[ch] == CNT_LAST) begin
          r_cnt[ch]  <= '0;
          r_o[ch]    <= w_s[ch];
          r_rise[ch] <= w_s[ch];
          r_fall[ch] <= ~w_s[ch];
        end else begin
          r_cnt[ch] <= r_cnt[ch] + CW'(1);
        end
      end
    end
  end

  assign w_sinv_rise = w_sinv & ~r_sinv_prev;

  // NOTE: combinational blocks assign every output a default first, so no latch can be inferred.
  always_comb begin
    w_err_sum = {1'b0, r_err_cnt};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_err_sum = w_err_sum + 9'(w_sinv_rise[ch]);
    end
  end

  // A new invalid observation wins over a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_invalid   <= '0;
      r_sinv_prev <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_invalid   <= (r_invalid & ~{CHANNELS{INVALID_CLR}}) | w_sinv;
      r_sinv_prev <= w_sinv;
      r_err_cnt   <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
    end
  end

  assign O       = r_o;
  assign RISE    = r_rise;
  assign FALL    = r_fall;
  assign INVALID = r_invalid;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_diff_input_filter.sv
// Scoreboard bench for diff_input_filter: a default instance and an INVERT=4'b0001 instance share
// stimulus; a window-based reference model predicts every cycle's outputs for both.
module tb_diff_input_filter;

  localparam int         CH       = 4;
  localparam int         S        = 2;
  localparam int         F        = 4;
  localparam logic [3:0] INV_MASK = 4'b0001;
  localparam logic [3:0] IDLE_I   = 4'b0000;
  localparam logic [3:0] IDLE_IB  = 4'b1111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] I   = IDLE_I;
  logic [3:0] IB  = IDLE_IB;
  logic       INVALID_CLR = 1'b0;

  logic [3:0] o0, rise0, fall0, inval0;
  logic [7:0] err0;
  logic [3:0] o1, rise1, fall1, inval1;
  logic [7:0] err1;

  always #5 CLK = ~CLK;

  diff_input_filter #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_LEN(F), .INVERT(4'b0000)) dut (
    .CLK(CLK), .RST(RST), .I(I), .IB(IB), .O(o0), .RISE(rise0), .FALL(fall0),
    .INVALID(inval0), .INVALID_CLR(INVALID_CLR), .ERR_CNT(err0)
  );

  diff_input_filter #(.CHANNELS(CH), .SYNC_STAGES(S), .FILTER_LEN(F), .INVERT(INV_MASK)) dut_inv (
    .CLK(CLK), .RST(RST), .I(I), .IB(IB), .O(o1), .RISE(rise1), .FALL(fall1),
    .INVALID(inval1), .INVALID_CLR(INVALID_CLR), .ERR_CNT(err1)
  );

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] inval;
    logic [7:0] err;
  } exp_t;

  typedef struct packed {
    exp_t u1;
    exp_t u0;
  } exp_pair_t;

  typedef struct packed {
    logic [3:0] raw1;
    logic [3:0] raw0;
    logic [3:0] inv;
  } stage_t;

  exp_pair_t sb_q[$];
  stage_t    pipe_q[$];

  // Reference model state: the last F synchronized samples per unit, plus output-level state.
  logic [3:0] win [2][F];
  logic [3:0] m_o [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic [3:0] m_inval;
  logic [7:0] m_err;
  logic [3:0] m_prev;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int k = 0; k < S; k++) pipe_q.push_back('0);
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < F; k++) win[u][k] = '0;
      m_o[u]    = '0;
      m_rise[u] = '0;
      m_fall[u] = '0;
    end
    m_inval = '0;
    m_err   = '0;
    m_prev  = '0;
  endtask

  function automatic exp_pair_t model_expect();
    exp_pair_t e;
    e.u0 = '{o: m_o[0], rise: m_rise[0], fall: m_fall[0], inval: m_inval, err: m_err};
    e.u1 = '{o: m_o[1], rise: m_rise[1], fall: m_fall[1], inval: m_inval, err: m_err};
    return e;
  endfunction

  // One clock edge of the reference: delay inputs by S, flip an output once its last F samples all disagree.
  task automatic model_step();
    stage_t     cur, nxt;
    logic [3:0] s, new_o;
    logic       all_diff;
    int         n, sum;
    cur      = pipe_q.pop_front();
    nxt.raw0 = I & ~IB;
    nxt.raw1 = (I & ~IB) ^ INV_MASK;
    nxt.inv  = ~(I ^ IB);
    pipe_q.push_back(nxt);
    for (int u = 0; u < 2; u++) begin
      s = (u == 0) ? cur.raw0 : cur.raw1;
      for (int k = 0; k < F - 1; k++) win[u][k] = win[u][k+1];
      win[u][F-1] = s;
      new_o = m_o[u];
      for (int ch = 0; ch < CH; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < F; k++) if (win[u][k][ch] == m_o[u][ch]) all_diff = 1'b0;
        if (all_diff) new_o[ch] = ~m_o[u][ch];
      end
      m_rise[u] = new_o & ~m_o[u];
      m_fall[u] = ~new_o & m_o[u];
      m_o[u]    = new_o;
    end
    m_inval = (m_inval & ~{4{INVALID_CLR}}) | cur.inv;
    n       = $countones(cur.inv & ~m_prev);
    sum     = int'(m_err) + n;
    m_err   = (sum > 255) ? 8'hFF : 8'(sum);
    m_prev  = cur.inv;
  endtask

  task automatic drive(input logic [3:0] i_v, input logic [3:0] ib_v, input logic clr, input int n);
    repeat (n) begin
      I           = i_v;
      IB          = ib_v;
      INVALID_CLR = clr;
      @(posedge CLK);
      if (RST) sb_q.push_back('0);
      else begin
        model_step();
        sb_q.push_back(model_expect());
      end
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive(IDLE_I, IDLE_IB, 1'b0, n);
  endtask

  // Async reset lands mid-cycle: the not-yet-compared entry for this cycle becomes all-zero.
  task automatic pulse_reset(input logic [3:0] i_v, input logic [3:0] ib_v, input int n);
    RST = 1'b1;
    model_reset();
    if (sb_q.size() > 0) begin
      void'(sb_q.pop_back());
      sb_q.push_back('0);
    end
    drive(i_v, ib_v, 1'b0, n);
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_pair_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("u0.O",       32'(o0),     32'(e.u0.o));
      check("u0.RISE",    32'(rise0),  32'(e.u0.rise));
      check("u0.FALL",    32'(fall0),  32'(e.u0.fall));
      check("u0.INVALID", 32'(inval0), 32'(e.u0.inval));
      check("u0.ERR_CNT", 32'(err0),   32'(e.u0.err));
      check("u1.O",       32'(o1),     32'(e.u1.o));
      check("u1.RISE",    32'(rise1),  32'(e.u1.rise));
      check("u1.FALL",    32'(fall1),  32'(e.u1.fall));
      check("u1.INVALID", 32'(inval1), 32'(e.u1.inval));
      check("u1.ERR_CNT", 32'(err1),   32'(e.u1.err));
    end
  end

  initial begin
    logic [3:0] ri, rib;
    model_reset();
    idle(3);
    RST = 1'b0;
    check("reset_o0", 32'(o0), 32'd0);
    check("reset_err0", 32'(err0), 32'd0);

    // Inverted channel idling at I=0/IB=1 rises after the normal latency.
    idle(8);
    check("inv_idle_o1_0", 32'(o1[0]), 32'd1);
    check("inv_idle_o0", 32'(o0), 32'd0);

    // ch0 held high.
    drive(4'b0001, 4'b1110, 1'b0, 10);
    check("ch0_high_o0", 32'(o0), 32'b0001);
    idle(8);

    // ch1 3-cycle glitch, then a 4-cycle pulse.
    drive(4'b0010, 4'b1101, 1'b0, 3);
    idle(8);
    check("ch1_glitch_o0_1", 32'(o0[1]), 32'd0);
    drive(4'b0010, 4'b1101, 1'b0, 4);
    idle(2);
    check("ch1_pulse_o0_1", 32'(o0[1]), 32'd1);
    idle(8);
    check("ch1_pulse_back_o0_1", 32'(o0[1]), 32'd0);

    // ch2 illegal pair held, then cleared.
    drive(4'b0100, 4'b1111, 1'b0, 10);
    idle(4);
    check("ch2_invalid", 32'(inval0[2]), 32'd1);
    check("ch2_err", 32'(err0), 32'd1);
    check("ch2_o", 32'(o0[2]), 32'd0);
    drive(IDLE_I, IDLE_IB, 1'b1, 1);
    idle(3);
    check("ch2_cleared", 32'(inval0[2]), 32'd0);
    check("ch2_err_kept", 32'(err0), 32'd1);

    // ch3: clear coincides with sinv[3]=1, so set wins.
    drive(4'b1000, 4'b1111, 1'b0, 1);
    idle(1);
    drive(IDLE_I, IDLE_IB, 1'b1, 1);
    idle(3);
    check("ch3_set_wins", 32'(inval0[3]), 32'd1);
    check("ch3_err", 32'(err0), 32'd2);

    // All channels enter I==IB together, 70 times: error count saturates.
    repeat (70) begin
      drive(4'b1111, 4'b1111, 1'b0, 1);
      idle(1);
    end
    idle(4);
    check("err_sat_u0", 32'(err0), 32'd255);
    check("err_sat_u1", 32'(err1), 32'd255);
    drive(IDLE_I, IDLE_IB, 1'b1, 1);
    idle(8);

    // Reset at cnt=2 mid-transition; O then needs the full latency from release.
    drive(4'b0001, 4'b1110, 1'b0, S + 2);
    pulse_reset(4'b0001, 4'b1110, 2);
    check("rst_err", 32'(err0), 32'd0);
    drive(4'b0001, 4'b1110, 1'b0, S + F - 1);
    check("rst_not_yet", 32'(o0[0]), 32'd0);
    drive(4'b0001, 4'b1110, 1'b0, 1);
    check("rst_full_latency", 32'(o0[0]), 32'd1);
    idle(10);

    // Randomized segments: held levels of random length, occasional illegal pairs, clears, resets.
    for (int seg = 0; seg < 120; seg++) begin
      ri  = 4'($urandom_range(0, 15));
      rib = ~ri;
      for (int ch = 0; ch < CH; ch++) if ($urandom_range(0, 7) == 0) rib[ch] = ri[ch];
      if ($urandom_range(0, 59) == 0) pulse_reset(ri, rib, $urandom_range(1, 2));
      else drive(ri, rib, ($urandom_range(0, 9) == 0), $urandom_range(1, 7));
    end

    idle(2);
    @(negedge CLK);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
